// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin select-mux scheduler.
//   NREQ    : number of requesters sharing the mux
//   SELW    : width of the mux select
//   state_e : scheduler FSM states
package mux_sched_pkg;

  localparam int NREQ = 8;
  localparam int SELW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority picker for 8 requesters.
// Ports:
//   req [7:0] : request vector, bit i = requester i
//   ptr [2:0] : index that currently has the highest priority
//   any       : at least one request is set
//   idx [2:0] : first set request found searching ptr, ptr+1, ... modulo 8
module rr_pick8
  import mux_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            any,
  output logic [SELW-1:0] idx
);

  logic [NREQ-1:0] rot_s;
  logic [SELW-1:0] enc_s;

  // Index of the lowest set bit; zero when nothing is set (masked by any).
  function automatic logic [SELW-1:0] first_set(input logic [NREQ-1:0] v);
    logic [SELW-1:0] r;
    r = {SELW{1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = SELW'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Rotate right by ptr so bit 0 of rot_s is the highest-priority requester.
  always_comb begin
    rot_s = NREQ'({req, req} >> ptr);
    enc_s = first_set(rot_s);
  end

  assign any = |req;
  // Undo the rotation; the 3-bit add wraps modulo 8 naturally.
  assign idx = enc_s + ptr;

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one 8:1 single-bit select mux among 8 requesters.
// Ports:
//   CLK  : rising-edge clock
//   RST  : synchronous active-high reset
//   EN   : allows new grants when high; an active grant always completes
//   REQ  : request lines, bit i = requester i
//   I    : data bits, bit i = requester i
//   S    : registered select = index of the granted requester
//   GNT  : registered one-hot grant, zero when idle
//   BUSY : registered, high while a grant is active
//   OUT  : combinational I[S] while BUSY, else 0
module mux_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int HOLD = 4,
  parameter int CW   = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] I,
  output logic [SELW-1:0] S,
  output logic [NREQ-1:0] GNT,
  output logic            BUSY,
  output logic            OUT
);

  localparam logic [CW-1:0]   CNT_LOAD = CW'(HOLD - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [SELW-1:0] SEL_ONE  = SELW'(1);
  localparam logic [NREQ-1:0] GNT_ONE  = NREQ'(1);

  state_e          state_r;
  logic [CW-1:0]   cnt_r;
  logic [SELW-1:0] ptr_r;
  logic            pick_any_s;
  logic [SELW-1:0] pick_idx_s;

  rr_pick8 u_pick (
    .req (REQ),
    .ptr (ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // Scheduler FSM: arbitrate in IDLE, count down the grant window in GRANT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      ptr_r   <= {SELW{1'b0}};
      S       <= {SELW{1'b0}};
      GNT     <= {NREQ{1'b0}};
      BUSY    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (EN && pick_any_s) begin
            state_r <= GRANT;
            S       <= pick_idx_s;
            GNT     <= GNT_ONE << pick_idx_s;
            BUSY    <= 1'b1;
            cnt_r   <= CNT_LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          // EN and the other requesters are deliberately ignored here.
          if (REQ[S] && (cnt_r != {CW{1'b0}})) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            // Release: S keeps its value; the served index gets lowest priority.
            state_r <= IDLE;
            GNT     <= {NREQ{1'b0}};
            BUSY    <= 1'b0;
            ptr_r   <= S + SEL_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          GNT     <= {NREQ{1'b0}};
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

  // No register between I and OUT: the data bit passes straight through the mux.
  assign OUT = BUSY ? I[S] : 1'b0;

endmodule

// File: doc/mux_rr_sched.md
Name: mux_rr_sched

Overview:
- Round-robin scheduler that shares one 8:1 single-bit select mux among 8 requesters.
- Each requester i drives a request line REQ[i] and a data bit I[i]. The block chooses the requester, drives the 3-bit select S, and presents I[S] on OUT for a bounded grant window.
- Sits directly in front of the select datapath. It replaces static select wiring wherever several sources share one output line.

Parameters:
- HOLD, 4, maximum grant length in cycles; legal range 1..255.
- CW, 8, width of the grant counter; must satisfy 2**CW > HOLD.

Ports:
- CLK  input  1  rising-edge clock, the single clock of the block
- RST  input  1  synchronous, active-high reset
- EN  input  1  when low, no new grant is issued; an active grant still runs to completion
- REQ  input  8  request lines, bit i = requester i
- I  input  8  data bits, bit i = requester i
- S  output  3  registered mux select = index of the granted requester
- GNT  output  8  registered one-hot grant; all zero when idle
- BUSY  output  1  registered; high while in GRANT state
- OUT  output  1  combinational; I[S] when BUSY, else 0

Behaviour:
- Reset, sampled at a CLK edge while RST=1:
  - state=IDLE, S=0, GNT=0, BUSY=0, pointer PTR=0, counter CNT=0.
  - OUT=0 follows from BUSY=0.
  - RST overrides all other inputs.
  - RST asserted mid-grant aborts the grant at that edge; there is no completion cycle.
- State IDLE:
  - Transitions only when EN=1 and REQ!=0.
  - Winner = first set REQ bit searching PTR, PTR+1, ... modulo 8 (wrap 7 -> 0).
  - At that edge, register S=winner, GNT=1<<winner, BUSY=1, CNT=HOLD-1, and go to GRANT.
  - Latency: REQ visible before edge k -> S/GNT/BUSY valid after edge k (one cycle).
  - EN=0 or REQ=0: stay in IDLE; all outputs hold their idle values.
- State GRANT:
  - Each edge, if REQ[S]=1 and CNT!=0: CNT decrements; S and GNT hold.
  - Release occurs at the edge where REQ[S]=0 or CNT=0. At release:
    - state=IDLE, GNT=0, BUSY=0;
    - PTR=S+1 modulo 8 (7 wraps to 0);
    - S keeps its last value.
  - A requester holding REQ continuously gets exactly HOLD cycles of BUSY=1.
  - REQ[S] dropping in any cycle ends the grant at that edge. BUSY stays high for the cycle in which REQ[S] was seen low.
  - REQ bits other than REQ[S] are ignored during GRANT.
  - EN is ignored during GRANT.
- Turnaround: every release is followed by exactly one IDLE cycle (BUSY=0) before the next grant. Back-to-back grants are therefore spaced HOLD+1 cycles apart.
- Fairness:
  - The last-served index has the lowest priority at the next arbitration.
  - With all 8 requesting continuously, the grant order is 0,1,...,7,0,...
  - Worst-case wait is 7*(HOLD+1) cycles.
- HOLD=1: every grant lasts one cycle, with one IDLE cycle between grants.
- OUT is purely combinational from the registered S, BUSY and input I. There is no added latency from I to OUT.

Decomposition:
- Shared package mux_sched_pkg holds:
  - state enum (IDLE=1'b0, GRANT=1'b1);
  - NREQ=8;
  - SELW=3.
- One sub-module, rr_pick8: combinational rotating-priority picker.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any (1), idx[2:0].
  - Implementation: rotate req right by ptr, priority-encode, then add ptr modulo 8.
- The top module holds the FSM, counter, pointer and output registers.

Test Plan:
- Reset: RST=1 for 2 cycles with REQ=8'hFF -> S=0, GNT=0, BUSY=0, OUT=0. After release with HOLD=4: GNT=8'h01 one cycle later, BUSY high exactly 4 cycles, then 1 IDLE cycle, then GNT=8'h02.
- Full rotation: REQ=8'hFF held, I=8'hA5 -> GNT walks 01,02,04,...,80,01. S walks 0..7,0. OUT during each grant = I[S] (1,0,1,0,0,1,0,1).
- Early drop and wrap: REQ=8'h80 until the 2nd grant cycle, then REQ=8'h01 -> grant 7 ends after 2 BUSY cycles. PTR wraps to 0, and GNT=8'h01 follows after one IDLE cycle.
- Priority skip: PTR=3 (after serving 2), REQ=8'h05 -> winner is 0, not 2. S=0, GNT=8'h01.
- EN gating: EN=0 with REQ=8'h10 -> stays IDLE indefinitely. EN=1 -> GNT=8'h10 next cycle. EN=0 mid-grant -> grant still completes its HOLD cycles.
- Reset mid-grant: RST=1 in the 2nd cycle of a grant to requester 5 -> next cycle GNT=0, BUSY=0, S=0. The next grant starts search from PTR=0.
